// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared encodings for the execute stage
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;

  // Condition test for jXX/cmovXX; unknown condition codes never fire.
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic zf, lt;
    zf = cc[CC_ZF];
    lt = cc[CC_SF] ^ cc[CC_OF];
    case (fn)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = lt | zf;
      C_L:      cond_eval = lt;
      C_E:      cond_eval = zf;
      C_NE:     cond_eval = ~zf;
      C_GE:     cond_eval = ~lt;
      C_G:      cond_eval = ~lt & ~zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - combinational add/sub/and/xor ALU with ZF/SF/OF flags
module alu64
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   fn,
  output logic [W-1:0] e,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  // Subtract is b - a so that OPq computes rB - rA.
  always_comb begin
    e  = '0;
    of = 1'b0;
    case (fn)
      ALU_ADD: begin
        e  = b + a;
        of = (a[W-1] == b[W-1]) & (e[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        e  = b - a;
        of = (a[W-1] != b[W-1]) & (e[W-1] != b[W-1]);
      end
      ALU_AND: e = b & a;
      default: e = b ^ a;
    endcase
  end

  assign zf = (e == '0);
  assign sf = e[W-1];

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: operand select, ALU, CC register, Cnd
module execute_stage
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         stat_ok,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  output logic [W-1:0] valE,
  output logic         Cnd,
  output logic [2:0]   cc,
  output logic         err
);

  localparam logic [W-1:0] STACK_STEP = W'(8);

  logic [W-1:0] alu_a, alu_b, alu_e;
  logic [1:0]   alu_fn;
  logic         alu_zf, alu_sf, alu_of;
  logic         is_opq, illegal, accept, cc_we, cnd_next;

  always_comb begin
    alu_a = '0;
    case (icode)
      I_RRMOVQ, I_OPQ:              alu_a = valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
      I_CALL, I_PUSHQ:              alu_a = -STACK_STEP;
      I_RET, I_POPQ:                alu_a = STACK_STEP;
      default:                      alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
      default:                                                   alu_b = '0;
    endcase
  end

  assign is_opq  = (icode == I_OPQ);
  assign illegal = is_opq & (ifun[3:2] != 2'b00);
  assign alu_fn  = is_opq ? ifun[1:0] : ALU_ADD;

  alu64 #(.W(W)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .fn (alu_fn),
    .e  (alu_e),
    .zf (alu_zf),
    .sf (alu_sf),
    .of (alu_of)
  );

  assign accept = in_valid & ~stall;
  assign cc_we  = accept & stat_ok & is_opq & ~illegal;

  // Cnd reads the registered CC, i.e. the state left by the previous OPq.
  assign cnd_next = ((icode == I_RRMOVQ) | (icode == I_JXX)) ? cond_eval(ifun, cc) : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      valE      <= '0;
      Cnd       <= 1'b0;
      err       <= 1'b0;
      cc        <= CC_RESET;
    end else if (accept) begin
      out_valid <= 1'b1;
      valE      <= illegal ? '0 : alu_e;
      Cnd       <= cnd_next;
      err       <= illegal;
      if (cc_we)
        cc <= {alu_zf, alu_sf, alu_of};
    end else if (!stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage against a behavioural Y86 model
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        stat_ok = 1'b1;
  logic [3:0]  icode = 4'h0;
  logic [3:0]  ifun = 4'h0;
  logic [63:0] valA = '0, valB = '0, valC = '0;
  logic        out_valid;
  logic [63:0] valE;
  logic        Cnd;
  logic [2:0]  cc;
  logic        err;

  execute_stage #(.W(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .stat_ok(stat_ok),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .out_valid(out_valid), .valE(valE), .Cnd(Cnd), .cc(cc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] e;
    logic        c;
    logic        er;
    logic [2:0]  f;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  logic        m_v = 1'b0;
  logic [63:0] m_e = '0;
  logic        m_c = 1'b0;
  logic        m_er = 1'b0;
  logic [2:0]  m_cc = 3'b100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic cond_of(input logic [3:0] f, input logic [2:0] flags);
    logic z, s, o;
    {z, s, o} = flags;
    case (f)
      4'd0: return 1'b1;
      4'd1: return (s != o) || z;
      4'd2: return s != o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return s == o;
      4'd6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: per-cycle next state of the visible outputs, from the instruction set rules.
  task automatic model(input logic r, iv, st, ok, input logic [3:0] ic, fn,
                       input logic [63:0] a, b, c);
    logic [63:0] oa, ob, res;
    logic [64:0] wide;
    logic        ovf, bad;
    if (r) begin
      m_v = 0; m_e = 0; m_c = 0; m_er = 0; m_cc = 3'b100;
    end else if (st) begin
      // registers hold
    end else if (!iv) begin
      m_v = 0;
    end else begin
      case (ic)
        4'h2, 4'h6:       oa = a;
        4'h3, 4'h4, 4'h5: oa = c;
        4'h8, 4'hA:       oa = 64'hFFFF_FFFF_FFFF_FFF8;
        4'h9, 4'hB:       oa = 64'd8;
        default:          oa = 0;
      endcase
      ob = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? b : 64'd0;
      ovf = 0;
      if (ic == 4'h6 && fn == 4'd1) begin
        wide = {ob[63], ob} - {oa[63], oa};
        res = wide[63:0];
        ovf = wide[64] != wide[63];
      end else if (ic == 4'h6 && fn == 4'd2) res = oa & ob;
      else if (ic == 4'h6 && fn == 4'd3)     res = oa ^ ob;
      else begin
        wide = {ob[63], ob} + {oa[63], oa};
        res = wide[63:0];
        ovf = wide[64] != wide[63];
      end
      bad  = (ic == 4'h6) && (fn > 4'd3);
      m_c  = (ic == 4'h2 || ic == 4'h7) ? cond_of(fn, m_cc) : 1'b0;
      m_e  = bad ? 64'd0 : res;
      m_er = bad;
      m_v  = 1;
      if (ok && ic == 4'h6 && !bad)
        m_cc = {res == 64'd0, res[63], ovf};
    end
    q.push_back('{m_v, m_e, m_c, m_er, m_cc});
  endtask

  task automatic drive(input logic r, iv, st, ok, input logic [3:0] ic, fn,
                       input logic [63:0] a, b, c);
    @(negedge clk);
    reset = r; in_valid = iv; stall = st; stat_ok = ok;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    model(r, iv, st, ok, ic, fn, a, b, c);
  endtask

  function automatic logic [63:0] rval();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: one expected record per clock edge after stimulus starts.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("out_valid", {63'd0, out_valid}, {63'd0, x.v});
        check("valE", valE, x.e);
        check("Cnd", {63'd0, Cnd}, {63'd0, x.c});
        check("err", {63'd0, err}, {63'd0, x.er});
        check("cc", {61'd0, cc}, {61'd0, x.f});
      end
    end
  end

  initial begin
    logic [3:0] ric, rfn;
    drive(1, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    drive(0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    drive(0, 1, 0, 1, 4'h6, 4'h1, 64'd5, 64'd3, 0);
    drive(0, 1, 0, 1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    drive(0, 1, 0, 1, 4'h7, 4'h1, 0, 0, 64'h40);
    drive(0, 1, 0, 1, 4'h7, 4'h2, 0, 0, 64'h40);
    drive(0, 1, 0, 1, 4'h7, 4'h4, 0, 0, 64'h40);
    drive(0, 1, 0, 1, 4'h6, 4'h2, 64'hB, 64'h4, 0);
    drive(0, 1, 0, 1, 4'h2, 4'h3, 64'h55, 64'h99, 0);
    drive(0, 1, 0, 1, 4'hA, 4'h0, 64'h7, 64'h100, 0);
    drive(0, 1, 0, 1, 4'hB, 4'h0, 64'h7, 64'h100, 0);
    drive(0, 1, 0, 0, 4'h6, 4'h1, 64'd1, 64'd1, 0);
    drive(0, 1, 0, 1, 4'h6, 4'h5, 64'd9, 64'd2, 0);
    drive(0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    drive(0, 1, 0, 1, 4'h6, 4'h1, 64'd3, 64'd3, 0);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 1, 1, 4'h6, 4'h1, 64'd1 + i, 64'd0, 64'd7);
    drive(1, 1, 1, 1, 4'h6, 4'h1, 64'd1, 64'd0, 0);
    drive(0, 0, 1, 1, 4'h0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      ric = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) ric = 4'($urandom_range(6, 7));
      rfn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) != 0, ric, rfn, rval(), rval(), rval());
    end
    drive(0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("drain", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
